serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer. It owns one FullAdder instance and drives it one bit per cycle, LSB first, over WIDTH cycles, holding the carry in a flip-flop between bits. Operands enter and results leave through valid/ready handshakes. It sits between an operand source (register file or test driver) and a result consumer, and trades area for latency against a ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand source has a request
start_ready  output  1  block can accept a request
a_in  input  WIDTH  operand A, sampled on acceptance
b_in  input  WIDTH  operand B, sampled on acceptance
cin_in  input  1  initial carry, sampled on acceptance
res_valid  output  1  result available
res_ready  input  1  consumer takes result
sum_out  output  WIDTH  sum result, stable while res_valid
cout_out  output  1  final carry out, stable while res_valid
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, any time, asynchronous): state=IDLE; shift regs, carry reg, counter, sum_out, cout_out=0; res_valid=0; busy=0; start_ready=1 once state is IDLE. Reset during RUN aborts the operation; no partial result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid && start_ready: latch a_in->a_sh, b_in->b_sh, cin_in->carry; counter=0; go to RUN.
- RUN: start_ready=0. FullAdder inputs are a_sh[0], b_sh[0] and carry. Each edge: carry<=cout; sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1; counter+1. On the edge where counter==WIDTH-1, go to DONE.
- DONE: res_valid=1, sum_out=sum_sh, cout_out=carry, both held stable. On res_ready, go to IDLE. start_valid is not accepted in DONE; there is one IDLE cycle minimum between results.
- Latency: if the request is accepted at edge k, res_valid is high after edge k+WIDTH. Throughput is one op per WIDTH+2 cycles when res_ready is held high.
- start_valid in RUN or DONE: ignored. The source must hold it until it sees start_ready.
- res_ready while res_valid=0: ignored.
- Arithmetic: sum_out = (a+b+cin) mod 2^WIDTH; cout_out = bit WIDTH of the full sum.
- Counter width: $clog2(WIDTH), minimum 1. WIDTH=1 completes in one RUN cycle.
- Wrap: the counter is reset on every acceptance and never wraps within an op.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined: adds input port op_sub (1 bit, sampled on acceptance). When op_sub=1, b_in is latched inverted and carry is initialised to 1, ignoring cin_in. Result = a-b mod 2^WIDTH, and cout_out=1 means no borrow. When op_sub=0, behaviour is identical to the base block.
- Undefined: the port is absent and the block only adds.

Decomposition:
- Package serial_add_pkg: state enum typedef (IDLE/RUN/DONE) and a localparam function for counter width.
- Sub-module: the existing FullAdder, instantiated once. No other sub-module; the FSM, shifters and carry flop stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0 -> sum=0x96, cout=0; res_valid exactly 8 cycles after the acceptance edge.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid. Pulse start_valid meanwhile -> sum/cout stable, start_ready=0, no second acceptance. Release -> IDLE, next op accepted.
- Assert rst_n=0 mid-RUN (after 3 bits) -> all outputs 0 immediately, state IDLE, no res_valid. A new op then completes correctly.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1 after 1 cycle.
- SERIAL_ADD_SUB_EN: op_sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. Then a=0x00, b=0x01 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder sequencer:
//   - state_t   : sequencer states (IDLE, RUN, DONE)
//   - cnt_width : bit-counter width for a given operand width ($clog2, min 1)
// ---------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-bit operand still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder shared by the serial sequencer.
// Ports:
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder sequencer. One full adder is driven one bit per cycle,
// LSB first, over WIDTH cycles; the carry is held in a flop between bits.
// Operands arrive on a valid/ready request; the result leaves on a
// valid/ready response and is held stable until taken.
//
// Parameters:
//   WIDTH       operand/result width (>= 1)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  operand source has a request
//   start_ready  block can accept a request (IDLE)
//   a_in, b_in   operands, sampled on acceptance
//   cin_in       initial carry, sampled on acceptance
//   op_sub       (SERIAL_ADD_SUB_EN only) 1 = compute a_in - b_in
//   res_valid    result available (DONE)
//   res_ready    consumer takes the result
//   sum_out      sum, stable while res_valid
//   cout_out     final carry out (no-borrow when subtracting), stable while res_valid
//   busy         high in RUN or DONE
//
// Build option:
//   SERIAL_ADD_SUB_EN  adds op_sub; b is latched inverted with carry-in 1.
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    assign accept   = start_valid && (state_q == IDLE);
    assign last_bit = (state_q == RUN) && (cnt == LAST);

    // Subtraction is a + ~b + 1: invert b at load time and force carry-in.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = op_sub ? ~b_in : b_in;
    assign carry_load = op_sub ? 1'b1 : cin_in;
`else
    assign b_load     = b_in;
    assign carry_load = cin_in;
`endif

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_sum),
        .co (fa_cout)
    );

    // New sum bits enter at the MSB so that after WIDTH shifts the LSB
    // computed first sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_sum_one
            assign sum_next = fa_sum;
        end else begin : g_sum_wide
            assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: state and datapath flops use non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, sum shifter, carry flop and bit counter.
    // The counter is held on the last bit so it never wraps within an op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_next;
            carry  <= fa_cout;
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Nothing changes these registers in DONE, so the result is stable
    // for as long as res_valid is held.
    assign sum_out  = sum_sh;
    assign cout_out = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl: a WIDTH=8 instance and a WIDTH=1
// instance. Expected results come from plain integer arithmetic.
// With SERIAL_ADD_SUB_EN defined the subtract path is exercised as well.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W8      = 8;
    localparam int TIMEOUT = 50;

    logic clk;
    logic rst_n;

    // WIDTH=8 instance signals
    logic          sv8, sr8, rv8, rr8, cin8, cout8, busy8, os8;
    logic [W8-1:0] a8, b8, sum8;

    // WIDTH=1 instance signals
    logic sv1, sr1, rv1, rr1, cin1, cout1, busy1, os1;
    logic a1, b1, sum1;

    int vectors;
    int miscompares;

    serial_add_ctrl #(.WIDTH(W8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv8),
        .start_ready (sr8),
        .a_in        (a8),
        .b_in        (b8),
        .cin_in      (cin8),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub      (os8),
`endif
        .res_valid   (rv8),
        .res_ready   (rr8),
        .sum_out     (sum8),
        .cout_out    (cout8),
        .busy        (busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv1),
        .start_ready (sr1),
        .a_in        (a1),
        .b_in        (b1),
        .cin_in      (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub      (os1),
`endif
        .res_valid   (rv1),
        .res_ready   (rr1),
        .sum_out     (sum1),
        .cout_out    (cout1),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout, sum} of a + b + cin; for subtraction the difference
    // mod 256 with cout meaning "no borrow" (a >= b).
    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
        int unsigned t;
        logic [7:0]  d;
        if (sub) begin
            d = a - b;
            return {a >= b, d};
        end
        t = int'(a) + int'(b) + int'(cin);
        return t[8:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 operation, with 'hold' cycles of result backpressure
    // during which start_valid is pulsed with junk operands.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub, input int hold);
        logic [8:0] exp;
        int         n;
        exp  = ref8(a, b, cin, sub);
        a8   = a;
        b8   = b;
        cin8 = cin;
        os8  = sub;
        sv8  = 1'b1;
        n    = 0;
        while (!sr8 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("start_ready_wait", 32'(sr8), 32'd1);
        tick();                        // acceptance edge
        sv8  = 1'b0;
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        cin8 = 1'($urandom);
        os8  = 1'($urandom);
        check("busy_run", 32'(busy8), 32'd1);
        check("start_ready_run", 32'(sr8), 32'd0);
        for (int i = 1; i <= W8; i++) begin
            tick();
            if (i == W8 - 1) check("res_valid_early", 32'(rv8), 32'd0);
        end
        check("res_valid_latency", 32'(rv8), 32'd1);
        check("sum", 32'(sum8), 32'(exp[7:0]));
        check("cout", 32'(cout8), 32'(exp[8]));
        for (int h = 0; h < hold; h++) begin
            sv8 = ~h[0];
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            tick();
            check("hold_res_valid", 32'(rv8), 32'd1);
            check("hold_sum", 32'(sum8), 32'(exp[7:0]));
            check("hold_cout", 32'(cout8), 32'(exp[8]));
            check("hold_start_ready", 32'(sr8), 32'd0);
        end
        sv8 = 1'b0;
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        check("release_res_valid", 32'(rv8), 32'd0);
        check("release_busy", 32'(busy8), 32'd0);
        check("release_start_ready", 32'(sr8), 32'd1);
    endtask

    // One WIDTH=1 operation: result must appear one edge after acceptance.
    task automatic run_op1(input logic a, input logic b, input logic cin);
        logic [1:0] exp;
        exp  = 2'(a) + 2'(b) + 2'(cin);
        a1   = a;
        b1   = b;
        cin1 = cin;
        sv1  = 1'b1;
        check("w1_start_ready", 32'(sr1), 32'd1);
        tick();                        // acceptance edge
        sv1 = 1'b0;
        check("w1_res_valid_early", 32'(rv1), 32'd0);
        tick();
        check("w1_res_valid", 32'(rv1), 32'd1);
        check("w1_sum", 32'(sum1), 32'(exp[0]));
        check("w1_cout", 32'(cout1), 32'(exp[1]));
        rr1 = 1'b1;
        tick();
        rr1 = 1'b0;
        check("w1_release", 32'(rv1), 32'd0);
    endtask

    initial begin
        logic       any_rv;
        logic       rs;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        {sv8, rr8, cin8, os8, a8, b8} = '0;
        {sv1, rr1, cin1, os1, a1, b1} = '0;

        // Reset state
        #12;
        check("rst_start_ready", 32'(sr8), 32'd1);
        check("rst_res_valid", 32'(rv8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed additions
        run_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0);

        // Backpressure with start_valid pulses in DONE
        run_op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 5);
        run_op8(8'h12, 8'h34, 1'b1, 1'b0, 0);

        // Reset in the middle of RUN
        a8   = 8'hC3;
        b8   = 8'h5F;
        cin8 = 1'b1;
        os8  = 1'b0;
        sv8  = 1'b1;
        tick();                        // acceptance edge (DUT is IDLE)
        sv8 = 1'b0;
        check("pre_abort_busy", 32'(busy8), 32'd1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(rv8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_start_ready", 32'(sr8), 32'd1);
        tick();
        rst_n  = 1'b1;
        any_rv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_rv = any_rv | rv8;
        end
        check("abort_no_result", 32'(any_rv), 32'd0);
        run_op8(8'h80, 8'h80, 1'b1, 1'b0, 1);

        // WIDTH=1 instance
        run_op1(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op1(1'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction; cin must be ignored when op_sub is set
        run_op8(8'h10, 8'h01, 1'b0, 1'b1, 0);
        run_op8(8'h00, 8'h01, 1'b1, 1'b1, 0);
        run_op8(8'h7E, 8'h7E, 1'b0, 1'b1, 0);
`endif

        // Randomized operations with random backpressure
        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op8(8'($urandom), 8'($urandom), 1'($urandom), rs,
                    int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
